fir2d_kernel_filter: RTL and testbench

- Parametrised successor of the fixed 5x5 luma FIR top, generalised in pixel width, coefficient width and kernel size.
- Adds a coefficient loader FSM, zero-padded top/left borders, rounding/saturation with a flag, and a frame-latched bypass.
- Sits between the video source (y/dv/hs/vs) and the RGB output stage.
- Coefficients are read from an external BRAM during vertical sync.

---
 rtl/fir2d_kernel_filter.sv | 249 ++++++++++++++++++++++++
 tb/tb_fir2d_kernel_filter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir2d_kernel_filter.sv
// rtl/fir2d_kernel_filter.sv - KxK 2D FIR filter with BRAM coefficient loader, zero padding, saturation and bypass
module fir2d_kernel_filter #(
    parameter int DW    = 8,
    parameter int CW    = 16,
    parameter int K     = 5,
    parameter int MAX_W = 2048,
    parameter int FRAC  = 8,
    localparam int AW   = $clog2((K*K+1)/2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   y_i,
    input  logic            dv_i,
    input  logic            hs_i,
    input  logic            vs_i,
    input  logic            bypass_i,
    input  logic [2*CW-1:0] coeff_data_i,
    output logic [AW-1:0]   coeff_addr_o,
    output logic            coeff_busy_o,
    output logic [DW-1:0]   y_o,
    output logic            dv_o,
    output logic            hs_o,
    output logic            vs_o,
    output logic            sat_o,
    output logic            line_ovf_o
);
    localparam int NT     = K*K;
    localparam int NW     = (NT+1)/2;
    localparam int XW     = $clog2(MAX_W+1);
    localparam int LW     = $clog2(MAX_W);
    localparam int YW     = 12;
    localparam int PW     = DW+1+CW;
    localparam int SW     = DW+1+CW+$clog2(NT);
    localparam int CENTRE = (K/2)*K + K/2;
    localparam logic signed [SW-1:0] RND  = SW'(1 << (FRAC-1));
    localparam logic signed [SW-1:0] YMAX = SW'((1 << DW) - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_STORE} state_t;

    state_t                  r_state;
    logic [AW-1:0]           r_addr;
    logic                    r_busy;
    logic signed [CW-1:0]    r_shadow [2*NW];
    logic signed [CW-1:0]    r_coeff  [NT];
    logic                    r_hs_d, r_vs_d, r_bypass, r_ovf;
    logic [XW-1:0]           r_x_cnt;
    logic [YW-1:0]           r_y_cnt;
    logic [DW-1:0]           r_line [K-1][MAX_W];
    logic [DW-1:0]           r_win  [K][K];
    logic [XW-1:0]           r_win_x;
    logic [YW-1:0]           r_win_y;
    logic signed [PW-1:0]    r_prod [K][K];
    logic signed [SW-1:0]    r_row  [K];
    logic [3:0]              r_dv_p, r_hs_p, r_vs_p;
    logic [DW-1:0]           r_yb   [3];
    logic [DW-1:0]           r_y_o;
    logic                    r_sat_o;

    logic                    w_hs_rise, w_vs_rise;
    logic [XW-1:0]           w_x_eff;
    logic [YW-1:0]           w_y_eff;
    logic [LW-1:0]           w_x_addr;
    logic [DW-1:0]           w_col  [K];
    logic signed [SW-1:0]    w_row  [K];
    logic signed [SW-1:0]    w_total, w_round;
    logic [DW-1:0]           w_y_filt;
    logic                    w_sat;

    // A sync edge coinciding with a pixel applies to that pixel's coordinates
    always_comb begin
        w_hs_rise = hs_i & ~r_hs_d;
        w_vs_rise = vs_i & ~r_vs_d;
        w_x_eff   = w_hs_rise ? '0 : r_x_cnt;
        if (w_vs_rise)
            w_y_eff = '0;
        else if (w_hs_rise && r_y_cnt != '1)
            w_y_eff = r_y_cnt + 1'b1;
        else
            w_y_eff = r_y_cnt;
        w_x_addr = (w_x_eff >= XW'(MAX_W)) ? LW'(MAX_W-1) : w_x_eff[LW-1:0];
    end

    always_comb begin
        for (int i = 0; i < K-1; i++)
            w_col[i] = r_line[K-2-i][w_x_addr];
        w_col[K-1] = y_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs_d   <= 1'b0;
            r_vs_d   <= 1'b0;
            r_x_cnt  <= '0;
            r_y_cnt  <= '0;
            r_ovf    <= 1'b0;
            r_bypass <= 1'b0;
        end else begin
            r_hs_d  <= hs_i;
            r_vs_d  <= vs_i;
            r_y_cnt <= w_y_eff;
            if (dv_i && w_x_eff != XW'(MAX_W))
                r_x_cnt <= w_x_eff + 1'b1;
            else
                r_x_cnt <= w_x_eff;
            if (w_vs_rise) begin
                r_ovf    <= 1'b0;
                r_bypass <= bypass_i;
            end else if (dv_i && w_x_eff == XW'(MAX_W)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Line buffers form a cascade: line 0 is the previous line, line K-2 the oldest
    always_ff @(posedge clk) begin
        if (dv_i) begin
            r_line[0][w_x_addr] <= y_i;
            for (int k = 1; k < K-1; k++)
                r_line[k][w_x_addr] <= r_line[k-1][w_x_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            for (int t = 0; t < 2*NW; t++)
                r_shadow[t] <= '0;
            for (int t = 0; t < NT; t++)
                r_coeff[t] <= (t == CENTRE) ? CW'(1 << FRAC) : '0;
        end else if (w_vs_rise) begin
            r_state <= S_REQ;
            r_addr  <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_IDLE;
                S_REQ:   r_state <= S_WAIT;
                S_WAIT: begin
                    r_shadow[{r_addr, 1'b0}] <= coeff_data_i[CW-1:0];
                    r_shadow[{r_addr, 1'b1}] <= coeff_data_i[2*CW-1:CW];
                    r_state <= S_STORE;
                end
                S_STORE: begin
                    if (r_addr < AW'(NW-1)) begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        for (int t = 0; t < NT; t++)
                            r_coeff[t] <= r_shadow[t];
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_row[i] = '0;
            for (int j = 0; j < K; j++)
                w_row[i] = w_row[i] + SW'(r_prod[i][j]);
        end
    end

    always_comb begin
        w_total = '0;
        for (int i = 0; i < K; i++)
            w_total = w_total + r_row[i];
        w_round  = (w_total + RND) >>> FRAC;
        w_sat    = 1'b0;
        w_y_filt = w_round[DW-1:0];
        if (w_round[SW-1]) begin
            w_y_filt = '0;
            w_sat    = 1'b1;
        end else if (w_round > YMAX) begin
            w_y_filt = '1;
            w_sat    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_x <= '0;
            r_win_y <= '0;
            r_dv_p  <= '0;
            r_hs_p  <= '0;
            r_vs_p  <= '0;
            r_y_o   <= '0;
            r_sat_o <= 1'b0;
            for (int i = 0; i < 3; i++)
                r_yb[i] <= '0;
            for (int i = 0; i < K; i++) begin
                r_row[i] <= '0;
                for (int j = 0; j < K; j++) begin
                    r_win[i][j]  <= '0;
                    r_prod[i][j] <= '0;
                end
            end
        end else begin
            r_dv_p  <= {r_dv_p[2:0], dv_i};
            r_hs_p  <= {r_hs_p[2:0], hs_i};
            r_vs_p  <= {r_vs_p[2:0], vs_i};
            r_yb[0] <= y_i;
            r_yb[1] <= r_yb[0];
            r_yb[2] <= r_yb[1];
            if (dv_i) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K-1; j++)
                        r_win[i][j] <= r_win[i][j+1];
                    r_win[i][K-1] <= w_col[i];
                end
                r_win_x <= w_x_eff;
                r_win_y <= w_y_eff;
            end
            // Taps above the first line or left of the first column read as zero
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    if (r_win_y < YW'(K-1-i) || r_win_x < XW'(K-1-j))
                        r_prod[i][j] <= '0;
                    else
                        r_prod[i][j] <= PW'($signed({1'b0, r_win[i][j]})) * PW'(r_coeff[i*K+j]);
            for (int i = 0; i < K; i++)
                r_row[i] <= w_row[i];
            if (!r_dv_p[2]) begin
                r_y_o   <= '0;
                r_sat_o <= 1'b0;
            end else if (r_bypass) begin
                r_y_o   <= r_yb[2];
                r_sat_o <= 1'b0;
            end else begin
                r_y_o   <= w_y_filt;
                r_sat_o <= w_sat;
            end
        end
    end

    assign coeff_addr_o = r_addr;
    assign coeff_busy_o = r_busy;
    assign y_o          = r_y_o;
    assign dv_o         = r_dv_p[3];
    assign hs_o         = r_hs_p[3];
    assign vs_o         = r_vs_p[3];
    assign sat_o        = r_sat_o;
    assign line_ovf_o   = r_ovf;
endmodule

// File: tb/tb_fir2d_kernel_filter.sv
// tb/tb_fir2d_kernel_filter.sv - bench for fir2d_kernel_filter against a direct-convolution reference
module tb_fir2d_kernel_filter;
    localparam int DW = 8, CW = 16, K = 5, MAX_W = 16, FRAC = 8, AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] y_i = '0;
    logic          dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, bypass_i = 1'b0;
    logic [31:0]   coeff_data_i = '0;
    logic [AW-1:0] coeff_addr_o;
    logic          coeff_busy_o;
    logic [DW-1:0] y_o;
    logic          dv_o, hs_o, vs_o, sat_o, line_ovf_o;

    always #5 clk = ~clk;

    fir2d_kernel_filter #(.DW(DW), .CW(CW), .K(K), .MAX_W(MAX_W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .bypass_i(bypass_i), .coeff_data_i(coeff_data_i), .coeff_addr_o(coeff_addr_o),
        .coeff_busy_o(coeff_busy_o), .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .sat_o(sat_o), .line_ovf_o(line_ovf_o)
    );

    // Coefficient BRAM with one cycle of read latency
    logic [31:0] bram [16];
    always @(posedge clk) coeff_data_i <= bram[coeff_addr_o];

    int          n_cmp = 0, n_fail = 0;
    int          img [8][20];
    int          mk [25];
    int          bk [25];
    int          my = 0;
    bit          mbp = 1'b0;
    bit          bp_req = 1'b0;
    logic [11:0] expq [$];
    int          addr_log [$];
    int          last_addr = -1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input int x, input int y);
        longint s = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                if (y-4+i >= 0 && x-4+j >= 0)
                    s += longint'(mk[i*5+j]) * img[y-4+i][x-4+j];
        s = (s + 128) >>> 8;
        if (s < 0)   return {1'b1, 8'd0};
        if (s > 255) return {1'b1, 8'd255};
        return {1'b0, 8'(s)};
    endfunction

    // One cycle: check the output due from 4 cycles ago, then drive new inputs
    task automatic step(input logic [7:0] s_y, input logic s_dv, input logic s_hs,
                        input logic s_vs, input logic [11:0] exp);
        logic [11:0] e;
        @(negedge clk);
        if (expq.size() == 4) begin
            e = expq.pop_front();
            chk("out", int'({dv_o, hs_o, vs_o, sat_o, y_o}), int'(e));
        end
        if (coeff_busy_o && int'(coeff_addr_o) != last_addr) begin
            addr_log.push_back(int'(coeff_addr_o));
            last_addr = int'(coeff_addr_o);
        end
        y_i = s_y; dv_i = s_dv; hs_i = s_hs; vs_i = s_vs; bypass_i = bp_req;
        expq.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(8'd0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic vs_pulse(input bit bp);
        bp_req = bp;
        step(8'd0, 1'b0, 1'b0, 1'b1, 12'h200);
        addr_log.delete();
        last_addr = -1;
        step(8'd0, 1'b0, 1'b0, 1'b1, 12'h200);
        step(8'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        my = 0;
        mbp = bp;
    endtask

    task automatic set_bram();
        for (int w = 0; w < 13; w++) begin
            int hi;
            hi = (2*w+1 < 25) ? bk[2*w+1] : 16'hDEAD;
            bram[w] = {16'(hi), 16'(bk[2*w])};
        end
    endtask

    task automatic wait_load();
        int n = 0;
        while (coeff_busy_o && n < 300) begin
            idle(1);
            n++;
        end
        chk("load_done", int'(coeff_busy_o), 0);
        for (int t = 0; t < 25; t++) mk[t] = bk[t];
    endtask

    task automatic check_addr_seq();
        chk("addr_cnt", addr_log.size(), 13);
        for (int k = 0; k < addr_log.size() && k < 13; k++) chk("addr_seq", addr_log[k], k);
    endtask

    // mode 0: ramp 8*row+col, 1: constant, 2: random
    task automatic send_row(input int w, input int mode, input int val);
        int p;
        logic [8:0] m;
        for (int x = 0; x < w; x++) begin
            p = (mode == 0) ? 8*my + x : (mode == 1) ? val : int'($urandom_range(0, 255));
            img[my][x] = p;
            m = model(x, my);
            if (mbp) step(8'(p), 1'b1, 1'b0, 1'b0, {1'b1, 2'b00, 1'b0, 8'(p)});
            else     step(8'(p), 1'b1, 1'b0, 1'b0, {1'b1, 2'b00, m});
        end
        step(8'd0, 1'b0, 1'b1, 1'b0, 12'h400);
        idle(2);
        my++;
    endtask

    task automatic send_frame(input int rows, input int mode, input int val);
        for (int r = 0; r < rows; r++) send_row(8, mode, val);
        idle(6);
    endtask

    task automatic set_identity();
        for (int t = 0; t < 25; t++) mk[t] = (t == 12) ? 256 : 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_y"}, int'(y_o), 0);
        chk({tag, "_dv"}, int'(dv_o), 0);
        chk({tag, "_hs"}, int'(hs_o), 0);
        chk({tag, "_vs"}, int'(vs_o), 0);
        chk({tag, "_sat"}, int'(sat_o), 0);
        chk({tag, "_ovf"}, int'(line_ovf_o), 0);
        chk({tag, "_busy"}, int'(coeff_busy_o), 0);
        chk({tag, "_addr"}, int'(coeff_addr_o), 0);
    endtask

    initial begin
        int n;
        for (int w = 0; w < 16; w++) bram[w] = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        set_identity();

        // Identity kernel from reset on a ramp frame
        send_frame(8, 0, 0);

        // All taps 1.0 on a constant frame of 10
        for (int t = 0; t < 25; t++) bk[t] = 256;
        set_bram();
        vs_pulse(1'b0);
        wait_load();
        check_addr_seq();
        send_frame(8, 1, 10);

        // Saturation high and low with a single centre tap
        for (int t = 0; t < 25; t++) bk[t] = (t == 12) ? 1024 : 0;
        set_bram();
        vs_pulse(1'b0);
        wait_load();
        send_frame(8, 1, 100);
        for (int t = 0; t < 25; t++) bk[t] = (t == 12) ? -256 : 0;
        set_bram();
        vs_pulse(1'b0);
        wait_load();
        send_frame(8, 1, 100);

        // Load restarted at addr 6; old bank stays active until completion
        for (int t = 0; t < 25; t++) bk[t] = 128;
        set_bram();
        vs_pulse(1'b0);
        n = 0;
        while (last_addr != 6 && n < 100) begin
            idle(1);
            n++;
        end
        chk("reach_addr6", last_addr, 6);
        vs_pulse(1'b0);
        send_row(8, 1, 50);
        wait_load();
        check_addr_seq();
        for (int r = 1; r < 8; r++) send_row(8, 1, 50);
        idle(6);

        // Random kernels on random frames
        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < 25; t++) bk[t] = int'($urandom_range(0, 384)) - 192;
            set_bram();
            vs_pulse(1'b0);
            wait_load();
            check_addr_seq();
            send_frame(8, 2, 0);
        end

        // Bypass request mid-frame takes effect only at the next frame
        vs_pulse(1'b0);
        wait_load();
        for (int r = 0; r < 4; r++) send_row(8, 2, 0);
        bp_req = 1'b1;
        for (int r = 4; r < 8; r++) send_row(8, 2, 0);
        idle(6);
        vs_pulse(1'b1);
        wait_load();
        send_frame(8, 0, 0);
        vs_pulse(1'b0);
        wait_load();

        // Over-long line sets the sticky overflow flag
        chk("ovf_before", int'(line_ovf_o), 0);
        send_row(20, 1, 30);
        idle(6);
        chk("ovf_set", int'(line_ovf_o), 1);
        idle(3);
        chk("ovf_sticky", int'(line_ovf_o), 1);
        vs_pulse(1'b0);
        chk("ovf_clear", int'(line_ovf_o), 0);
        wait_load();
        idle(6);

        // Reset mid-frame, then identity kernel restored
        for (int r = 0; r < 3; r++) send_row(8, 0, 0);
        step(8'd7, 1'b1, 1'b0, 1'b0, 12'h000);
        step(8'd9, 1'b1, 1'b0, 1'b0, 12'h000);
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        expq.delete();
        @(negedge clk);
        y_i = '0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; bp_req = 1'b0; bypass_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_identity();
        my = 0;
        mbp = 1'b0;
        send_frame(8, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
